// File: rtl/n64_poll_sched.sv
`default_nettype none
// ============================================================================
//  Module   : n64_poll_sched
//  Purpose  : Round-robin poll scheduler for the shared N64 controller
//             receiver. Once per frame it walks port_sel over ports 0..3,
//             issues one go pulse per port, then collects the 32-bit response
//             or times it out. It maintains the presence/data snapshot that
//             the SPI slave reads.
//  Ports    : clk, reset         - CLK_25 domain clock, sync active-high reset
//             enable             - allows new frames to start
//             port_sel[1:0]      - controller line routed to receiver din
//             go                 - one-cycle start pulse to N64_recv
//             data_valid/data_in - response strobe and word from N64_recv
//             ctrl_present[3:0]  - per-port responding flag
//             ctrl_data[127:0]   - port i word at [32i+31:32i]
//             frame_done         - one-cycle pulse after port 3 completes
//             busy               - frame in progress
//             overrun_cnt[7:0]   - saturating count of ticks dropped while busy
//  Revision : 1.0 - initial release
// ============================================================================
module n64_poll_sched #(
    parameter int CLK_FREQ       = 25_000_000,
    parameter int POLL_HZ        = 100,
    parameter int TIMEOUT_CYCLES = 25_000,
    parameter int SETTLE         = 4,
    parameter int MISS_LIMIT     = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    output logic [1:0]   port_sel,
    output logic         go,
    input  logic         data_valid,
    input  logic [31:0]  data_in,
    output logic [3:0]   ctrl_present,
    output logic [127:0] ctrl_data,
    output logic         frame_done,
    output logic         busy,
    output logic [7:0]   overrun_cnt
);

    localparam int c_period = CLK_FREQ / POLL_HZ;
    localparam int c_per_w  = (c_period > 1) ? $clog2(c_period) : 1;
    localparam int c_to_w   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int c_st_w   = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [c_per_w-1:0] c_per_last = c_per_w'(c_period - 1);
    localparam logic [c_to_w-1:0]  c_to_last  = c_to_w'(TIMEOUT_CYCLES - 1);
    localparam logic [c_st_w-1:0]  c_st_last  = c_st_w'(SETTLE - 1);
    localparam logic [3:0]         c_miss_max = 4'(MISS_LIMIT);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SEL  = 3'd1,
        S_GO   = 3'd2,
        S_WAIT = 3'd3,
        S_NEXT = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // Frame-rate tick. The tick is registered, so it is high for one cycle
    // exactly PERIOD cycles after reset releases and every PERIOD thereafter.
    // ------------------------------------------------------------------------
    logic [c_per_w-1:0] r_period_cnt;
    logic               r_tick;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_period_cnt <= '0;
            r_tick       <= 1'b0;
        end else if (r_period_cnt == c_per_last) begin
            r_period_cnt <= '0;
            r_tick       <= 1'b1;
        end else begin
            r_period_cnt <= r_period_cnt + c_per_w'(1);
            r_tick       <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Poll sequencer state
    // ------------------------------------------------------------------------
    state_t              r_state;
    logic [1:0]          r_idx;
    logic [c_st_w-1:0]   r_settle_cnt;
    logic [c_to_w-1:0]   r_wait_cnt;
    logic [3:0][3:0]     r_miss;
    logic [3:0]          r_present;
    logic [127:0]        r_data;
    logic                r_go;
    logic                r_busy;
    logic                r_frame_done;
    logic [7:0]          r_overrun;

    state_t              w_state_nxt;
    logic [1:0]          w_idx_nxt;
    logic [c_st_w-1:0]   w_settle_nxt;
    logic [c_to_w-1:0]   w_wait_nxt;
    logic [3:0][3:0]     w_miss_nxt;
    logic [3:0]          w_present_nxt;
    logic [127:0]        w_data_nxt;
    logic                w_done_nxt;
    logic [7:0]          w_overrun_nxt;
    logic [3:0]          w_miss_cur;
    logic [3:0]          w_miss_inc;

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_settle_nxt  = r_settle_cnt;
        w_wait_nxt    = r_wait_cnt;
        w_miss_nxt    = r_miss;
        w_present_nxt = r_present;
        w_data_nxt    = r_data;
        w_done_nxt    = 1'b0;
        w_overrun_nxt = r_overrun;

        // Saturating miss increment for the port currently being polled
        w_miss_cur = r_miss[r_idx];
        w_miss_inc = (w_miss_cur >= c_miss_max) ? c_miss_max : (w_miss_cur + 4'd1);

        // A tick arriving while any frame is in flight is dropped and counted
        if (r_tick && (r_state != S_IDLE) && (r_overrun != 8'hFF)) begin
            w_overrun_nxt = r_overrun + 8'd1;
        end

        case (r_state)
            S_IDLE: begin
                if (r_tick && enable) begin
                    w_state_nxt  = S_SEL;
                    w_idx_nxt    = 2'd0;
                    w_settle_nxt = '0;
                end
            end
            S_SEL: begin
                // Let the selected line settle through the mux before go
                if (r_settle_cnt == c_st_last) begin
                    w_state_nxt = S_GO;
                end else begin
                    w_settle_nxt = r_settle_cnt + c_st_w'(1);
                end
            end
            S_GO: begin
                w_state_nxt = S_WAIT;
                w_wait_nxt  = '0;
            end
            S_WAIT: begin
                // Valid is tested first so it wins on the expiry cycle
                if (data_valid) begin
                    w_data_nxt[{r_idx, 5'd0} +: 32] = data_in;
                    w_present_nxt[r_idx]            = 1'b1;
                    w_miss_nxt[r_idx]               = 4'd0;
                    w_state_nxt                     = S_NEXT;
                end else if (r_wait_cnt == c_to_last) begin
                    w_miss_nxt[r_idx] = w_miss_inc;
                    // Below the limit the last good word is held
                    if (w_miss_inc == c_miss_max) begin
                        w_present_nxt[r_idx]            = 1'b0;
                        w_data_nxt[{r_idx, 5'd0} +: 32] = 32'd0;
                    end
                    w_state_nxt = S_NEXT;
                end else begin
                    w_wait_nxt = r_wait_cnt + c_to_w'(1);
                end
            end
            S_NEXT: begin
                if (r_idx == 2'd3) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_idx_nxt    = r_idx + 2'd1;
                    w_settle_nxt = '0;
                    w_state_nxt  = S_SEL;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_idx        <= 2'd0;
            r_settle_cnt <= '0;
            r_wait_cnt   <= '0;
            r_miss       <= '0;
            r_present    <= 4'd0;
            r_data       <= 128'd0;
            r_go         <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_overrun    <= 8'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_settle_cnt <= w_settle_nxt;
            r_wait_cnt   <= w_wait_nxt;
            r_miss       <= w_miss_nxt;
            r_present    <= w_present_nxt;
            r_data       <= w_data_nxt;
            // Registered from next state: go is high exactly while in GO
            r_go         <= (w_state_nxt == S_GO);
            r_busy       <= (w_state_nxt != S_IDLE);
            r_frame_done <= w_done_nxt;
            r_overrun    <= w_overrun_nxt;
        end
    end

    assign port_sel     = r_idx;
    assign go           = r_go;
    assign ctrl_present = r_present;
    assign ctrl_data    = r_data;
    assign frame_done   = r_frame_done;
    assign busy         = r_busy;
    assign overrun_cnt  = r_overrun;

endmodule
`default_nettype wire

// File: doc/n64_poll_sched.md
# n64_poll_sched

Round-robin poll scheduler for the N64 controller receiver. Replaces the free-running `go` counter in the top level. It steps a port-select mux across up to four controller data lines and issues one `go` per port to the shared N64 receiver. It then collects each 32-bit response or times it out, and maintains the `ctrl_present`/`ctrl_data` snapshot consumed by the SPI slave.

## Interface
- `CLK_FREQ`, 25_000_000: clock frequency in Hz.
- `POLL_HZ`, 100: frame rate. PERIOD = CLK_FREQ/POLL_HZ cycles; PERIOD ≥ 4·(SETTLE+TIMEOUT_CYCLES+4).
- `TIMEOUT_CYCLES`, 25_000: maximum wait for `data_valid` after `go`.
- `SETTLE`, 4: cycles between `port_sel` change and `go`; ≥1.
- `MISS_LIMIT`, 3: consecutive timeouts before a port is declared absent; 1–15.
- `clk` in 1: system clock (CLK_25 domain).
- `reset` in 1: synchronous, active-high.
- `enable` in 1: permits new frames to start.
- `port_sel` out 2: selects which controller line drives the receiver `din`.
- `go` out 1: one-cycle start pulse to N64_recv.
- `data_valid` in 1: response strobe from N64_recv.
- `data_in` in 32: response word from N64_recv.
- `ctrl_present` out 4: bit i = port i responding.
- `ctrl_data` out 128: port i word at [32i+31:32i].
- `frame_done` out 1: one-cycle pulse after port 3 completes.
- `busy` out 1: high while a frame is in progress.
- `overrun_cnt` out 8: saturating count of period ticks dropped while busy.

## Operation
- Period counter is free-running: 0..PERIOD-1. A tick is asserted when count = PERIOD-1, and the counter then wraps to 0. First tick is PERIOD cycles after `reset` falls.
- FSM states: IDLE, SEL, GO, WAIT, NEXT.
- IDLE: on tick with `enable`=1 → SEL, idx=0, `busy`=1. Tick with `enable`=0 is ignored and not counted.
- SEL: `port_sel`=idx; wait SETTLE cycles → GO.
- GO: `go`=1 for exactly one cycle; clear timeout counter → WAIT.
- WAIT: counter increments each cycle.
  - `data_valid`=1 → latch `data_in` into slice idx, set `ctrl_present[idx]`, clear miss[idx] → NEXT.
  - Counter reaches TIMEOUT_CYCLES-1 without valid → miss[idx] += 1, saturating at MISS_LIMIT. If miss[idx] reaches MISS_LIMIT: clear `ctrl_present[idx]` and zero slice idx. Otherwise slice and present bit are unchanged (last good data held). → NEXT.
- NEXT: if idx=3 → pulse `frame_done`, `busy`=0 → IDLE; else idx+1 → SEL.
- `data_valid` outside WAIT is ignored; no state or data change.
- `data_valid` in the same cycle as timeout expiry: valid wins.
- Tick while `busy`=1: frame is not restarted; `overrun_cnt` += 1, saturating at 255.
- `enable` falling mid-frame: current frame runs to completion; no new frame starts.
- `reset` mid-frame: immediate return to IDLE; all state cleared.

## Timing
- Reset values:
  - `port_sel`=0, `go`=0, `ctrl_present`=0, `ctrl_data`=0, `frame_done`=0, `busy`=0, `overrun_cnt`=0.
  - Miss counters 0; period counter 0.
- All outputs are registered.
- `go` asserts SETTLE+1 cycles after the tick cycle (1 cycle IDLE→SEL, SETTLE cycles in SEL).
- `ctrl_data`/`ctrl_present` update in the cycle after `data_valid` is sampled.
- Timeout decision falls TIMEOUT_CYCLES cycles after the `go` cycle.
- `port_sel` is stable from SEL entry until the next SEL; it never changes while in WAIT.
- `frame_done` is high for one cycle; `busy` falls in that same cycle.

## Test plan
Parameters for all scenarios: CLK_FREQ=1000, POLL_HZ=1 (PERIOD=1000), TIMEOUT_CYCLES=50, SETTLE=4, MISS_LIMIT=3.

- **Reset:** hold `reset` 5 cycles → all outputs 0. First `go` occurs 1005 cycles after `reset` falls, with `port_sel`=0.
- **All ports respond:** model returns 0x1111_0000+i 10 cycles after each `go`.
  - Exactly 4 `go` pulses, with `port_sel` 0,1,2,3.
  - `ctrl_present`=4'b1111 and `ctrl_data`=0x11110003_11110002_11110001_11110000.
  - One `frame_done` pulse.
- **Missing port:** port 2 silent after responding 0xDEADBEEF in frame 1.
  - Frames 2–3: `ctrl_present[2]`=1, slice holds 0xDEADBEEF.
  - Frame 4 (third miss): `ctrl_present[2]`=0, slice = 0.
  - A later response restores presence in one frame.
- **Stray and collision:** `data_valid` pulse while in IDLE → no change. `data_valid` on the exact timeout cycle → data latched, miss counter cleared.
- **Overrun:** force PERIOD < frame length (POLL_HZ=10, TIMEOUT=50, all ports silent) → `overrun_cnt` increments once per dropped tick and saturates at 255. `enable`=0 mid-frame → frame finishes and `busy` stays 0 thereafter.
- **Reset mid-WAIT:** assert `reset` during port 1 WAIT → next cycle IDLE, `busy`=0, `go`=0, `ctrl_present`=0, `ctrl_data`=0.
